// File: rtl/string2states.sv
// string2states: parses ASCII command lines from a host link into game
// configuration fields (wires, button, timer, strikes).
// Line format: <letter><payload><LF|CR>. A good line is committed to its
// output through a one-cycle COMMIT state; a bad line raises a one-cycle err.
// Optional build macro CASE_INSENSITIVE_EN: when defined, the lowercase
// command letters w/b/t/s are accepted as well as the uppercase ones.
module string2states (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic [5:0] wires_cfg,
    output logic [1:0] button_color,
    output logic [9:0] timer_secs,
    output logic [1:0] strikes,
    output logic       update,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE, WIRES, BUTTON, TIMER, STRIKES, DISCARD, COMMIT
    } state_t;

    state_t     state, state_nxt;
    logic [9:0] shadow, shadow_nxt;   // payload being assembled
    logic [2:0] count, count_nxt;     // payload characters taken so far
    logic       err_nxt;
    logic       load_wires, load_button, load_timer, load_strikes;

    logic       accept;
    logic       is_term;
    logic       is_digit;
    logic [3:0] digit;
    logic [7:0] letter;

    // A character moves only when both sides agree.
    assign accept   = char_valid && char_ready;
    assign is_term  = (char_in == 8'h0A) || (char_in == 8'h0D);
    assign is_digit = (char_in >= 8'h30) && (char_in <= 8'h39);
    assign digit    = char_in[3:0];

`ifdef CASE_INSENSITIVE_EN
    // Fold lowercase onto uppercase so both spellings decode the same.
    assign letter = ((char_in >= 8'h61) && (char_in <= 8'h7A)) ? (char_in & 8'hDF) : char_in;
`else
    assign letter = char_in;
`endif

    // Only COMMIT stalls the link; update marks that single cycle.
    assign char_ready = (state != COMMIT);
    assign update     = (state == COMMIT);

    // Next-state, payload accumulation and commit/error decisions.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_nxt    = state;
        shadow_nxt   = shadow;
        count_nxt    = count;
        err_nxt      = 1'b0;
        load_wires   = 1'b0;
        load_button  = 1'b0;
        load_timer   = 1'b0;
        load_strikes = 1'b0;

        if (state == COMMIT) begin
            state_nxt = IDLE;
        end else if (accept) begin
            unique case (state)
                IDLE: begin
                    shadow_nxt = '0;
                    count_nxt  = '0;
                    if (is_term)               state_nxt = IDLE;
                    else if (letter == 8'h57)  state_nxt = WIRES;    // 'W'
                    else if (letter == 8'h42)  state_nxt = BUTTON;   // 'B'
                    else if (letter == 8'h54)  state_nxt = TIMER;    // 'T'
                    else if (letter == 8'h53)  state_nxt = STRIKES;  // 'S'
                    else                       state_nxt = DISCARD;
                end
                WIRES: begin
                    if (is_term) begin
                        if (count == 3'd6) begin
                            state_nxt  = COMMIT;
                            load_wires = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            err_nxt   = 1'b1;
                        end
                    end else if ((char_in == 8'h30 || char_in == 8'h31) && count < 3'd6) begin
                        shadow_nxt = {shadow[8:0], char_in[0]};
                        count_nxt  = count + 3'd1;
                    end else begin
                        state_nxt = DISCARD;
                    end
                end
                BUTTON, STRIKES: begin
                    if (is_term) begin
                        if (count == 3'd1) begin
                            state_nxt    = COMMIT;
                            load_button  = (state == BUTTON);
                            load_strikes = (state == STRIKES);
                        end else begin
                            state_nxt = IDLE;
                            err_nxt   = 1'b1;
                        end
                    end else if (is_digit && count == 3'd0 &&
                                 digit <= ((state == BUTTON) ? 4'd3 : 4'd2)) begin
                        shadow_nxt = {6'd0, digit};
                        count_nxt  = 3'd1;
                    end else begin
                        state_nxt = DISCARD;
                    end
                end
                TIMER: begin
                    if (is_term) begin
                        if (count != 3'd0) begin
                            state_nxt  = COMMIT;
                            load_timer = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            err_nxt   = 1'b1;
                        end
                    end else if (is_digit && count < 3'd3) begin
                        // At most three digits, so the result never exceeds 999.
                        shadow_nxt = (shadow * 10'd10) + {6'd0, digit};
                        count_nxt  = count + 3'd1;
                    end else begin
                        state_nxt = DISCARD;
                    end
                end
                DISCARD: begin
                    if (is_term) begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, payload and output registers; outputs load on the edge into COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state        <= IDLE;
            shadow       <= '0;
            count        <= '0;
            err          <= 1'b0;
            wires_cfg    <= '0;
            button_color <= '0;
            timer_secs   <= 10'd300;
            strikes      <= '0;
        end else begin
            state  <= state_nxt;
            shadow <= shadow_nxt;
            count  <= count_nxt;
            err    <= err_nxt;
            if (load_wires)   wires_cfg    <= shadow[5:0];
            if (load_button)  button_color <= shadow[1:0];
            if (load_timer)   timer_secs   <= shadow;
            if (load_strikes) strikes      <= shadow[1:0];
        end
    end

endmodule

// File: tb/tb_string2states.sv
// Self-checking bench for string2states: a table of whole lines with their
// expected pulses and field values, hand sequences for timing/reset corners,
// and random lines checked against a line-level reference model.
module tb_string2states;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] char_in = 8'h00;
    logic       char_valid = 1'b0;
    logic       char_ready;
    logic [5:0] wires_cfg;
    logic [1:0] button_color;
    logic [9:0] timer_secs;
    logic [1:0] strikes;
    logic       update;
    logic       err;

    string2states dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .char_in      (char_in),
        .char_valid   (char_valid),
        .char_ready   (char_ready),
        .wires_cfg    (wires_cfg),
        .button_color (button_color),
        .timer_secs   (timer_secs),
        .strikes      (strikes),
        .update       (update),
        .err          (err)
    );

    always #5 clk = ~clk;

`ifdef CASE_INSENSITIVE_EN
    localparam bit CI = 1'b1;
`else
    localparam bit CI = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Pulse monitor, sampled on the falling edge.
    int upd_cnt = 0, err_cnt = 0, both_cnt = 0, rdy_bad = 0;
    always @(negedge clk) begin
        if (update) upd_cnt++;
        if (err) err_cnt++;
        if (update && err) both_cnt++;
        if (update && char_ready) rdy_bad++;
    end

    // Expected field values kept by the reference model.
    int exp_w = 0, exp_b = 0, exp_t = 300, exp_s = 0;

    typedef struct {
        string      line;
        logic [7:0] term;
        int         upd;
        int         er;
        int         w;
        int         b;
        int         t;
        int         s;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_fields(input string tag, input int w, input int b, input int t, input int s);
        check({tag, ".wires"},   int'(wires_cfg),    w);
        check({tag, ".button"},  int'(button_color), b);
        check({tag, ".timer"},   int'(timer_secs),   t);
        check({tag, ".strikes"}, int'(strikes),      s);
    endtask

    // Line-level reference: decide the outcome of one line from the command rules.
    task automatic model_line(input string line, output int upd, output int er);
        byte c, ch;
        int  n, val, wv;
        bit  all_dig, all_bin, ok;
        upd = 0; er = 0;
        if (line.len() == 0) return;
        c = line[0];
        if (CI && c >= 8'h61 && c <= 8'h7A) c = c - 8'd32;
        n = line.len() - 1;
        all_dig = 1; all_bin = 1; val = 0; wv = 0;
        for (int i = 1; i <= n; i++) begin
            ch = line[i];
            if (ch < 8'h30 || ch > 8'h39) all_dig = 0;
            else val = val * 10 + int'(ch - 8'h30);
            if (ch != 8'h30 && ch != 8'h31) all_bin = 0;
            else wv = wv * 2 + int'(ch - 8'h30);
        end
        ok = 0;
        case (c)
            8'h57: if (all_bin && n == 6)             begin ok = 1; exp_w = wv;  end
            8'h42: if (all_dig && n == 1 && val <= 3) begin ok = 1; exp_b = val; end
            8'h54: if (all_dig && n >= 1 && n <= 3)   begin ok = 1; exp_t = val; end
            8'h53: if (all_dig && n == 1 && val <= 2) begin ok = 1; exp_s = val; end
            default: ok = 0;
        endcase
        if (ok) upd = 1; else er = 1;
    endtask

    // Present one character, wait (bounded) until it is taken; returns on the next falling edge.
    task automatic send(input logic [7:0] c, input int gap);
        int w;
        for (int g = 0; g < gap; g++) begin
            char_valid = 1'b0;
            char_in    = 8'($urandom);
            @(negedge clk);
        end
        char_in    = c;
        char_valid = 1'b1;
        w = 0;
        while (!char_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (w >= 8) begin
            n_checks++;
            $display("FAIL send_timeout: char_ready low for %0d cycles, expected high within 8", w);
        end
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic send_line(input string line, input logic [7:0] term, input int gap_max);
        for (int i = 0; i < line.len(); i++) send(line[i], $urandom_range(0, gap_max));
        send(term, $urandom_range(0, gap_max));
    endtask

    // Send a line, let it settle, and compare pulses counted during it.
    task automatic run_line(input string tag, input string line, input logic [7:0] term,
                            input int gap_max, input int eu, input int ee);
        int u0, e0;
        u0 = upd_cnt; e0 = err_cnt;
        send_line(line, term, gap_max);
        repeat (3) @(negedge clk);
        check({tag, ".update_pulses"}, upd_cnt - u0, eu);
        check({tag, ".err_pulses"},    err_cnt - e0, ee);
    endtask

    function automatic vec_t mk(string l, logic [7:0] term, int u, int e, int w, int b, int t, int s);
        vec_t v;
        v.line = l; v.term = term; v.upd = u; v.er = e;
        v.w = w; v.b = b; v.t = t; v.s = s;
        return v;
    endfunction

    function automatic string rand_line();
        string cmds;
        string s;
        byte   cmd, ch;
        int    n, r;
        cmds = "WBTSwbtsQ";
        if ($urandom_range(0, 11) == 0) return "";
        cmd = cmds[$urandom_range(0, 8)];
        s = $sformatf("%c", cmd);
        n = $urandom_range(0, 7);
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)                              ch = 8'h41 + 8'($urandom_range(0, 25));
            else if ((cmd & 8'hDF) == 8'h57 && r < 9) ch = 8'h30 + 8'($urandom_range(0, 1));
            else                                     ch = 8'h30 + 8'($urandom_range(0, 9));
            s = $sformatf("%s%c", s, ch);
        end
        return s;
    endfunction

    vec_t vecs[$];

    initial begin
        int w1, eu, ee, u0, e0;
        string l;
        logic [7:0] term;

        w1 = CI ? 63 : 0;
        vecs.push_back(mk("S3",       8'h0A, 0, 1, 0,  0, 300, 0));
        vecs.push_back(mk("T1234",    8'h0A, 0, 1, 0,  0, 300, 0));
        vecs.push_back(mk("w111111",  8'h0A, CI ? 1 : 0, CI ? 0 : 1, w1, 0, 300, 0));
        vecs.push_back(mk("T120",     8'h0A, 1, 0, w1, 0, 120, 0));
        vecs.push_back(mk("W101100",  8'h0D, 1, 0, 44, 0, 120, 0));
        vecs.push_back(mk("",         8'h0A, 0, 0, 44, 0, 120, 0));
        vecs.push_back(mk("S2",       8'h0A, 1, 0, 44, 0, 120, 2));
        vecs.push_back(mk("B4",       8'h0A, 0, 1, 44, 0, 120, 2));
        vecs.push_back(mk("W10110",   8'h0A, 0, 1, 44, 0, 120, 2));
        vecs.push_back(mk("W1011001", 8'h0A, 0, 1, 44, 0, 120, 2));
        vecs.push_back(mk("W102100",  8'h0A, 0, 1, 44, 0, 120, 2));
        vecs.push_back(mk("T7",       8'h0D, 1, 0, 44, 0, 7,   2));
        vecs.push_back(mk("",         8'h0A, 0, 0, 44, 0, 7,   2));
        vecs.push_back(mk("T099",     8'h0A, 1, 0, 44, 0, 99,  2));
        vecs.push_back(mk("S",        8'h0A, 0, 1, 44, 0, 99,  2));
        vecs.push_back(mk("T",        8'h0D, 0, 1, 44, 0, 99,  2));
        vecs.push_back(mk("Q1",       8'h0A, 0, 1, 44, 0, 99,  2));
        vecs.push_back(mk("B3",       8'h0A, 1, 0, 44, 3, 99,  2));
        vecs.push_back(mk("S12",      8'h0A, 0, 1, 44, 3, 99,  2));
        vecs.push_back(mk("B",        8'h0A, 0, 1, 44, 3, 99,  2));

        // Reset state.
        repeat (2) @(negedge clk);
        check_fields("reset", 0, 0, 300, 0);
        check("reset.char_ready", int'(char_ready), 1);
        check("reset.update",     int'(update),     0);
        check("reset.err",        int'(err),        0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of whole lines.
        foreach (vecs[i]) begin
            l = $sformatf("vec%0d", i);
            run_line(l, vecs[i].line, vecs[i].term, 1, vecs[i].upd, vecs[i].er);
            check_fields(l, vecs[i].w, vecs[i].b, vecs[i].t, vecs[i].s);
        end
        exp_w = 44; exp_b = 3; exp_t = 99; exp_s = 2;

        // Commit latency: output/update in N+1, char_ready back in N+2.
        u0 = upd_cnt;
        send(8'h54, 0); send(8'h31, 0); send(8'h32, 0); send(8'h30, 0);
        send(8'h0A, 0);
        check("lat.update_n1", int'(update),     1);
        check("lat.ready_n1",  int'(char_ready), 0);
        check("lat.timer_n1",  int'(timer_secs), 120);
        @(negedge clk);
        check("lat.update_n2", int'(update),     0);
        check("lat.ready_n2",  int'(char_ready), 1);
        repeat (2) @(negedge clk);
        check("lat.update_pulses", upd_cnt - u0, 1);
        exp_t = 120;

        // Button with char_valid dropped between characters.
        run_line("gap_b2", "B2", 8'h0A, 4, 1, 0);
        exp_b = 2;
        check_fields("gap_b2", exp_w, exp_b, exp_t, exp_s);

        // Random lines against the reference model.
        for (int k = 0; k < 120; k++) begin
            l    = rand_line();
            term = ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h0D;
            model_line(l, eu, ee);
            if (term == 8'h0D && $urandom_range(0, 1) == 0) begin
                send_line(l, term, 2);
                run_line($sformatf("rnd%0d", k), "", 8'h0A, 2, eu, ee);
            end else begin
                run_line($sformatf("rnd%0d", k), l, term, 2, eu, ee);
            end
            check_fields($sformatf("rnd%0d", k), exp_w, exp_b, exp_t, exp_s);
        end

        // Reset mid-line drops the partial timer line.
        u0 = upd_cnt; e0 = err_cnt;
        send(8'h54, 0); send(8'h34, 0); send(8'h35, 0);
        rst_n = 1'b0;
        #1;
        check("rst_async.timer", int'(timer_secs), 300);
        check("rst_async.ready", int'(char_ready), 1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        send(8'h0A, 0);
        repeat (3) @(negedge clk);
        check("rst_mid.update_pulses", upd_cnt - u0, 0);
        check("rst_mid.err_pulses",    err_cnt - e0, 0);
        check_fields("rst_mid", 0, 0, 300, 0);

        check("never_update_and_err", both_cnt, 0);
        check("ready_low_in_commit",  rdy_bad,  0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/string2states.md
STRING2STATES -- requirements
Module: string2states

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port char_in, input, 8 bits: ASCII character from the host link.
REQ-004 SHALL have port char_valid, input, 1 bit: char_in holds a character.
REQ-005 SHALL have port char_ready, output, 1 bit: the block can accept a character; a character transfers only on a cycle with char_valid=1 and char_ready=1.
REQ-006 SHALL have port wires_cfg, output, 6 bits: wire-module cut pattern.
REQ-007 SHALL have port button_color, output, 2 bits: button-module colour code.
REQ-008 SHALL have port timer_secs, output, 10 bits: countdown start value, 0-999 seconds.
REQ-009 SHALL have port strikes, output, 2 bits: strike count, 0-2.
REQ-010 SHALL have port update, output, 1 bit: one-cycle pulse when a field is committed.
REQ-011 SHALL have port err, output, 1 bit: one-cycle pulse when a malformed line is rejected.

Function
REQ-012 SHALL parse lines of the form <letter><payload><term>, where term is 0x0A or 0x0D.
REQ-013 SHALL define the commands as follows:
- 'W' + exactly 6 chars from '0'/'1', MSB first -> wires_cfg
- 'B' + one digit 0-3 -> button_color
- 'T' + 1-3 decimal digits -> timer_secs
- 'S' + one digit 0-2 -> strikes
REQ-014 SHALL implement the FSM states IDLE, WIRES, BUTTON, TIMER, STRIKES, DISCARD and COMMIT.
REQ-015 SHALL, from IDLE, go to the matching command state on a valid letter, stay in IDLE on a terminator (empty line, no err), and go to DISCARD on any other character.
REQ-016 SHALL, in the command states, accumulate the payload into a shadow register; timer accumulation is acc*10+digit with a digit count.
REQ-017 SHALL go to DISCARD on any of these payload errors: non-digit, digit out of range, too many characters (7th wire char, 2nd B/S digit, 4th T digit).
REQ-018 SHALL, on a terminator in a command state with a complete payload, go to COMMIT; a complete payload is W=6 chars, B/S=1 digit, T>=1 digit.
REQ-019 SHALL go to IDLE and pulse err the next cycle on a terminator in a command state with an incomplete payload.
REQ-020 SHALL, in DISCARD, consume all characters until a terminator, then go to IDLE with err=1 in the following cycle.
REQ-021 SHALL, in COMMIT (one cycle), load the shadow value into the target output, drive update=1 and char_ready=0, then return to IDLE.
- Latency: terminator accepted in cycle N -> output and update valid in cycle N+1; char_ready=1 again in N+2.
REQ-022 SHALL change outputs only in COMMIT; a partial or rejected line leaves every output unchanged.
REQ-023 SHALL hold char_ready=1 in every state except COMMIT.
REQ-024 SHALL parse CR LF as a committed line followed by an ignored empty line.
REQ-025 SHALL ignore char_in while char_valid=0 or char_ready=0; no state change occurs on those cycles.
REQ-026 SHALL never assert update and err in the same cycle.

Reset
REQ-027 SHALL, on rst_n=0, immediately and asynchronously force: state IDLE, wires_cfg=0, button_color=0, timer_secs=300, strikes=0, update=0, err=0, char_ready=1, shadow registers and digit count cleared.
REQ-028 SHALL, on reset asserted mid-line, discard the partial line; the first character after release is treated as the start of a line.

Configuration
REQ-029 SHALL support macro CASE_INSENSITIVE_EN:
- Defined: lowercase 'w', 'b', 't', 's' are accepted equivalently to uppercase.
- Undefined: lowercase letters in IDLE cause DISCARD and err.

Verification
REQ-030 SHALL cover: "T120\n" -> one cycle after '\n': timer_secs=120, update=1 for 1 cycle, char_ready=0 for 1 cycle.
REQ-031 SHALL cover: "W101100\r\n" -> wires_cfg=6'b101100, exactly one update pulse, no err.
REQ-032 SHALL cover: "S3\n" then "T1234\n" -> two err pulses; strikes and timer_secs keep reset values 0/300.
REQ-033 SHALL cover: "B2\n" with char_valid toggled low between characters -> button_color=2, single update.
REQ-034 SHALL cover: "T45", then rst_n low for 2 cycles, then "\n" -> no update/err; timer_secs=300.
REQ-035 SHALL cover: "w111111\n" -> wires_cfg=6'b111111 with CASE_INSENSITIVE_EN defined; err pulse and wires_cfg=0 without it.
